// File: rtl/noise_pkg.sv
// Shared constants and helpers for the noise channel: divisor base table,
// timer width, no-step shift threshold and default parameter values.
package noise_pkg;

  localparam int LFSR_W_DEF    = 15;
  localparam int SHORT_TAP_DEF = 6;
  localparam int VOL_W_DEF     = 4;
  localparam int LEN_W_DEF     = 6;

  // Wide enough for the largest reload, 112 << 15.
  localparam int TIMER_W = 22;

  localparam logic [3:0] NO_STEP_SHIFT = 4'd14;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } envDir_e;

  // Code 0 is 8; codes 1..7 are 16*code.
  function automatic logic [6:0] divisorBase(input logic [2:0] code);
    divisorBase = (code == 3'd0) ? 7'd8 : {code, 4'b0000};
  endfunction

  function automatic logic [TIMER_W-1:0] timerReload(input logic [2:0] code,
                                                    input logic [3:0] shift);
    timerReload = {{(TIMER_W-7){1'b0}}, divisorBase(code)} << shift;
  endfunction

endpackage

// File: rtl/lfsr_noise_channel_if.sv
// Register/tick bundle between the frame sequencer / register file and a
// noise channel; the channel returns its status and output level.
interface lfsr_noise_channel_if
  import noise_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);
  logic             len_tick;
  logic             env_tick;
  logic [LEN_W-1:0] len_load;
  logic [VOL_W-1:0] start_vol;
  logic             env_add;
  logic [2:0]       env_period;
  logic [3:0]       clk_shift;
  logic             width_mode;
  logic [2:0]       divisor;
  logic             trigger;
  logic             len_enable;
  logic             active;
  logic [VOL_W-1:0] sample;

  modport master (
    output len_tick, env_tick, len_load, start_vol, env_add, env_period,
           clk_shift, width_mode, divisor, trigger, len_enable,
    input  active, sample
  );

  modport slave (
    input  len_tick, env_tick, len_load, start_vol, env_add, env_period,
           clk_shift, width_mode, divisor, trigger, len_enable,
    output active, sample
  );
endinterface

// File: rtl/vol_envelope.sv
// Volume envelope shared by the square, wave and noise channels: volume
// register, period counter and saturation stop.
module vol_envelope
  import noise_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             envTick,
  input  logic [VOL_W-1:0] startVol,
  input  logic             envAdd,
  input  logic [2:0]       envPeriod,
  output logic [VOL_W-1:0] volume
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  envDir_e    dirQ;
  logic [2:0] periodQ;
  logic [2:0] periodCnt;
  logic       stopped;
  logic       atLimit;

  assign atLimit = (dirQ == ENV_UP) ? (volume == VOL_MAX) : (volume == '0);

  // Period and direction are captured per note; a saturated note stays put
  // until the next trigger even if the limit would later be left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume    <= '0;
      periodCnt <= 3'd0;
      periodQ   <= 3'd0;
      dirQ      <= ENV_DOWN;
      stopped   <= 1'b0;
    end else if (trigger) begin
      volume    <= startVol;
      periodCnt <= envPeriod;
      periodQ   <= envPeriod;
      dirQ      <= envDir_e'(envAdd);
      stopped   <= 1'b0;
    end else if (envTick && (periodQ != 3'd0) && !stopped) begin
      if (periodCnt <= 3'd1) begin
        periodCnt <= periodQ;
        if (atLimit) begin
          stopped <= 1'b1;
        end else if (dirQ == ENV_UP) begin
          volume <= volume + VOL_W'(1);
        end else begin
          volume <= volume - VOL_W'(1);
        end
      end else begin
        periodCnt <= periodCnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/lfsr_noise_channel.sv
// Noise channel: divisor/shift timer clocking a 15/7-bit-mode LFSR, length
// counter and envelope, producing a registered volume-or-zero sample.
module lfsr_noise_channel
  import noise_pkg::*;
#(
  parameter int LFSR_W    = LFSR_W_DEF,
  parameter int SHORT_TAP = SHORT_TAP_DEF,
  parameter int VOL_W     = VOL_W_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_noise_channel_if.slave bus
);

  localparam logic [LEN_W:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};

  logic [LFSR_W-1:0]  sr;
  logic [TIMER_W-1:0] timerCnt;
  logic [LEN_W:0]     lenCnt;
  logic               activeQ;
  logic [VOL_W-1:0]   sampleQ;
  logic [3:0]         shiftQ;
  logic               modeQ;
  logic [VOL_W-1:0]   volume;
  logic               timerExpire;
  logic               lenStep;
  logic               dacOff;

  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] s,
                                                 input logic shortMode);
    logic              fb;
    logic [LFSR_W-1:0] n;
    fb = s[0] ^ s[1];
    n  = {fb, s[LFSR_W-1:1]};
    if (shortMode) n[SHORT_TAP] = fb;
    return n;
  endfunction

  assign timerExpire = activeQ && (timerCnt <= TIMER_W'(1));
  assign lenStep     = bus.len_tick && bus.len_enable && (lenCnt != '0);
  assign dacOff      = (bus.start_vol == '0) && !bus.env_add;

  // Shift and mode are sampled at each reload, so the step issued by a reload
  // still uses the settings of the period that just ended.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '1;
      timerCnt <= '0;
      lenCnt   <= '0;
      activeQ  <= 1'b0;
      shiftQ   <= 4'd0;
      modeQ    <= 1'b0;
    end else if (bus.trigger) begin
      sr       <= '1;
      timerCnt <= timerReload(bus.divisor, bus.clk_shift);
      shiftQ   <= bus.clk_shift;
      modeQ    <= bus.width_mode;
      lenCnt   <= LEN_FULL - {1'b0, bus.len_load};
      activeQ  <= !dacOff;
    end else begin
      if (timerExpire) begin
        timerCnt <= timerReload(bus.divisor, bus.clk_shift);
        shiftQ   <= bus.clk_shift;
        modeQ    <= bus.width_mode;
        if (shiftQ < NO_STEP_SHIFT) sr <= lfsrNext(sr, modeQ);
      end else if (activeQ) begin
        timerCnt <= timerCnt - TIMER_W'(1);
      end
      if (lenStep) begin
        lenCnt <= lenCnt - (LEN_W+1)'(1);
        if (lenCnt == (LEN_W+1)'(1)) activeQ <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleQ <= '0;
    end else begin
      sampleQ <= (activeQ && !sr[0]) ? volume : '0;
    end
  end

  vol_envelope #(.VOL_W(VOL_W)) uEnv (
    .clk      (clk),
    .rst_n    (rst_n),
    .trigger  (bus.trigger),
    .envTick  (bus.env_tick),
    .startVol (bus.start_vol),
    .envAdd   (bus.env_add),
    .envPeriod(bus.env_period),
    .volume   (volume)
  );

  assign bus.active = activeQ;
  assign bus.sample = sampleQ;

endmodule

// File: tb/tb_lfsr_noise_channel.sv
// Directed bench for lfsr_noise_channel with hand-computed expectations.
module tb_lfsr_noise_channel;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  lfsr_noise_channel_if bus ();

  lfsr_noise_channel dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  task automatic trig(input logic [3:0] sv, input logic add, input logic [2:0] per,
                      input logic [3:0] shift, input logic [2:0] div, input logic mode,
                      input logic [5:0] lenLoad, input logic lenEn);
    @(negedge clk);
    bus.start_vol  = sv;
    bus.env_add    = add;
    bus.env_period = per;
    bus.clk_shift  = shift;
    bus.divisor    = div;
    bus.width_mode = mode;
    bus.len_load   = lenLoad;
    bus.len_enable = lenEn;
    bus.trigger    = 1'b1;
    @(posedge clk);
    #1;
    bus.trigger = 1'b0;
  endtask

  // Short mode reaches sr[0]=0 at step 7; freezing the shift afterwards
  // parks the LFSR there so sample shows the volume directly.
  task automatic start_frozen(input logic [3:0] sv, input logic add, input logic [2:0] per,
                              input logic [5:0] lenLoad, input logic lenEn);
    trig(sv, add, per, 4'd0, 3'd0, 1'b1, lenLoad, lenEn);
    repeat (60) @(posedge clk);
    #1;
    bus.clk_shift = 4'd14;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_env();
    @(negedge clk);
    bus.env_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.env_tick = 1'b0;
  endtask

  task automatic pulse_len();
    @(negedge clk);
    bus.len_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.len_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL reset_active: got %b expected 0", bus.active);
    end
    checks++;
    if (bus.sample !== 4'd0) begin
      errors++; $display("FAIL reset_sample: got %0d expected 0", bus.sample);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL post_reset_active: got %b expected 0", bus.active);
    end
  endtask

  task automatic test_first_step();
    trig(4'd9, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL trig_active: got %b expected 1", bus.active);
    end
    repeat (120) @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0) begin
      errors++; $display("FAIL long_step15_pre: got %0d expected 0", bus.sample);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd9) begin
      errors++; $display("FAIL long_step15_voiced: got %0d expected 9", bus.sample);
    end
  endtask

  task automatic test_divisor_shift();
    trig(4'd12, 1'b0, 3'd0, 4'd1, 3'd1, 1'b1, 6'd0, 1'b0);
    repeat (224) @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0) begin
      errors++; $display("FAIL div1_shift1_pre: got %0d expected 0", bus.sample);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd12) begin
      errors++; $display("FAIL div1_shift1_voiced: got %0d expected 12", bus.sample);
    end
  endtask

  task automatic test_no_step();
    trig(4'd5, 1'b0, 3'd0, 4'd14, 3'd0, 1'b1, 6'd0, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0 || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL shift14_no_step: got sample %0d active %b expected 0 1", bus.sample, bus.active);
    end
  endtask

  task automatic test_short_period();
    bit voiced [1:254];
    int firstVoiced = 0;
    int mism = 0;
    int voicedCnt = 0;
    trig(4'd7, 1'b0, 3'd0, 4'd0, 3'd0, 1'b1, 6'd0, 1'b0);
    repeat (4) @(posedge clk);
    for (int n = 1; n <= 254; n++) begin
      repeat (8) @(posedge clk);
      #1;
      voiced[n] = (bus.sample != 4'd0);
    end
    for (int n = 1; n <= 127; n++) begin
      if (voiced[n] && firstVoiced == 0) firstVoiced = n;
      if (voiced[n] != voiced[n+127]) mism++;
      if (voiced[n]) voicedCnt++;
    end
    checks++;
    if (firstVoiced != 7) begin
      errors++; $display("FAIL short_first_voiced: got step %0d expected 7", firstVoiced);
    end
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL short_period127: got %0d differences expected 0", mism);
    end
    checks++;
    if (voicedCnt != 63) begin
      errors++; $display("FAIL short_voiced_count: got %0d expected 63", voicedCnt);
    end
  endtask

  task automatic test_envelope();
    logic [3:0] cSv  [5] = '{4'd5, 4'd15, 4'd1, 4'd14, 4'd6};
    logic       cAdd [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] cPer [5] = '{3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [3:0] cExp [5][4] = '{'{4'd5, 4'd4, 4'd4, 4'd3},
                                '{4'd15, 4'd15, 4'd15, 4'd15},
                                '{4'd0, 4'd0, 4'd0, 4'd0},
                                '{4'd15, 4'd15, 4'd15, 4'd15},
                                '{4'd6, 4'd6, 4'd6, 4'd6}};
    for (int c = 0; c < 5; c++) begin
      start_frozen(cSv[c], cAdd[c], cPer[c], 6'd0, 1'b0);
      checks++;
      if (bus.sample !== cSv[c]) begin
        errors++; $display("FAIL env_case%0d_start: got %0d expected %0d", c, bus.sample, cSv[c]);
      end
      for (int t = 0; t < 4; t++) begin
        pulse_env();
        @(posedge clk);
        #1;
        checks++;
        if (bus.sample !== cExp[c][t]) begin
          errors++;
          $display("FAIL env_case%0d_tick%0d: got %0d expected %0d", c, t + 1, bus.sample, cExp[c][t]);
        end
      end
    end
  endtask

  task automatic test_dac_off();
    trig(4'd0, 1'b0, 3'd1, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL dac_off_active: got %b expected 0", bus.active);
    end
    trig(4'd0, 1'b1, 3'd1, 4'd0, 3'd0, 1'b0, 6'd0, 1'b0);
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL vol0_add_active: got %b expected 1", bus.active);
    end
  endtask

  task automatic test_length();
    start_frozen(4'd7, 1'b0, 3'd0, 6'd62, 1'b1);
    pulse_len();
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL len_tick1_active: got %b expected 1", bus.active);
    end
    pulse_len();
    checks++;
    if (bus.active !== 1'b0 || bus.sample !== 4'd7) begin
      errors++;
      $display("FAIL len_tick2_edge: got active %b sample %0d expected 0 7", bus.active, bus.sample);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0) begin
      errors++; $display("FAIL len_tick2_sample: got %0d expected 0", bus.sample);
    end
    start_frozen(4'd7, 1'b0, 3'd0, 6'd63, 1'b0);
    repeat (3) pulse_len();
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL len_hold_active: got %b expected 1", bus.active);
    end
    bus.len_enable = 1'b1;
    pulse_len();
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL len_enable_expire: got %b expected 0", bus.active);
    end
  endtask

  task automatic test_simultaneous();
    trig(4'd9, 1'b0, 3'd3, 4'd0, 3'd0, 1'b1, 6'd62, 1'b1);
    repeat (23) @(posedge clk);
    #1;
    @(negedge clk);
    bus.trigger  = 1'b1;
    bus.len_tick = 1'b1;
    bus.env_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.trigger  = 1'b0;
    bus.len_tick = 1'b0;
    bus.env_tick = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0) begin
      errors++; $display("FAIL simul_step6_sample: got %0d expected 0", bus.sample);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd9) begin
      errors++; $display("FAIL simul_step7_sample: got %0d expected 9", bus.sample);
    end
    pulse_len();
    checks++;
    if (bus.active !== 1'b1) begin
      errors++; $display("FAIL simul_len_count: got active %b expected 1", bus.active);
    end
    pulse_len();
    checks++;
    if (bus.active !== 1'b0) begin
      errors++; $display("FAIL simul_len_expire: got active %b expected 0", bus.active);
    end
  endtask

  task automatic test_reset_mid_note();
    start_frozen(4'd11, 1'b0, 3'd0, 6'd0, 1'b0);
    checks++;
    if (bus.sample !== 4'd11) begin
      errors++; $display("FAIL mid_note_sample: got %0d expected 11", bus.sample);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sample !== 4'd0 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sample %0d active %b expected 0 0", bus.sample, bus.active);
    end
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (bus.sample !== 4'd0 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_silent: got sample %0d active %b expected 0 0", bus.sample, bus.active);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.len_tick   = 1'b0;
    bus.env_tick   = 1'b0;
    bus.len_load   = '0;
    bus.start_vol  = '0;
    bus.env_add    = 1'b0;
    bus.env_period = 3'd0;
    bus.clk_shift  = 4'd0;
    bus.width_mode = 1'b0;
    bus.divisor    = 3'd0;
    bus.trigger    = 1'b0;
    bus.len_enable = 1'b0;
    test_reset();
    test_first_step();
    test_divisor_shift();
    test_no_step();
    test_short_period();
    test_envelope();
    test_dac_off();
    test_length();
    test_simultaneous();
    test_reset_mid_note();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
